// File: rtl/axis_mem2s_if.sv
// AXI-Stream bundle carrying one sample per beat from the frame reader.
interface axis_mem2s_if #(
  parameter int unsigned DATA_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_mem2s.sv
// Streams one completed FFT frame out of mem0 (linear or bit-reversed order)
// through the mux read port, hiding the RAM's 1-cycle read latency.
module axis_mem2s #(
  parameter int unsigned FFT_SIZE   = 4096,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  bitrev_en,
  output logic                  busy,
  output logic                  done,
  output logic                  axis_tx,
  output logic                  axis_mem2m_clken,
  output logic [ADDR_WIDTH-1:0] axis_mem2m_raddr,
  input  logic [DATA_WIDTH-1:0] axis_mem2m_rdata,
  axis_mem2s_if.master          m_axis
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FFT_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      rd_cnt;
  logic [ADDR_WIDTH-1:0] out_cnt;
  logic                  bitrev;
  logic                  tvalid;
  logic                  tlast;
  logic                  rd_en;
  logic                  hs;

  function automatic logic [ADDR_WIDTH-1:0] bit_reverse(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ADDR_WIDTH; i++) begin
      r[i] = a[ADDR_WIDTH-1-i];
    end
    return r;
  endfunction

  assign hs = tvalid & m_axis.tready;

  // RAM read enable: one priming read, then one read per non-final accepted beat.
  // The counter MSB guard keeps reads from ever running past the frame.
  always_comb begin
    rd_en = 1'b0;
    case (state)
      PRIME:   rd_en = 1'b1;
      STREAM:  rd_en = m_axis.tready & ~tlast & ~rd_cnt[CNT_W-1];
      default: rd_en = 1'b0;
    endcase
  end

  // Read address from the registered counter, optionally bit-reversed.
  always_comb begin
    if (bitrev) begin
      axis_mem2m_raddr = bit_reverse(rd_cnt[ADDR_WIDTH-1:0]);
    end else begin
      axis_mem2m_raddr = rd_cnt[ADDR_WIDTH-1:0];
    end
  end

  assign axis_mem2m_clken = rd_en;
  assign m_axis.tdata     = axis_mem2m_rdata;
  assign m_axis.tvalid    = tvalid;
  assign m_axis.tlast     = tlast;

  // Frame sequencer with registered status and stream flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      out_cnt <= '0;
      bitrev  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      axis_tx <= 1'b0;
      tvalid  <= 1'b0;
      tlast   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bitrev  <= bitrev_en;
            rd_cnt  <= '0;
            out_cnt <= '0;
            busy    <= 1'b1;
            axis_tx <= 1'b1;
            state   <= PRIME;
          end
        end
        PRIME: begin
          rd_cnt <= rd_cnt + CNT_W'(1);
          tvalid <= 1'b1;
          tlast  <= 1'b0;
          state  <= STREAM;
        end
        STREAM: begin
          if (rd_en) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
          if (hs) begin
            if (tlast) begin
              tvalid  <= 1'b0;
              tlast   <= 1'b0;
              busy    <= 1'b0;
              axis_tx <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              out_cnt <= out_cnt + ADDR_WIDTH'(1);
              tlast   <= (out_cnt == LAST_IDX - ADDR_WIDTH'(1));
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_mem2s.sv
// Bench for axis_mem2s: 4096-point instance under random backpressure and
// restart/reset abuse, plus a 16-point bit-reversed instance.
module tb_axis_mem2s;

  localparam int unsigned NA  = 4096;
  localparam int unsigned AWA = 12;
  localparam int unsigned NB  = 16;
  localparam int unsigned AWB = 4;
  localparam int unsigned DW  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, br_a, start_b, br_b;
  logic busy_a, done_a, tx_a, clken_a;
  logic busy_b, done_b, tx_b, clken_b;
  logic [AWA-1:0] raddr_a;
  logic [AWB-1:0] raddr_b;
  logic [DW-1:0]  rdata_a, rdata_b;

  axis_mem2s_if #(.DATA_WIDTH(DW)) ax_a ();
  axis_mem2s_if #(.DATA_WIDTH(DW)) ax_b ();

  axis_mem2s #(.FFT_SIZE(NA), .ADDR_WIDTH(AWA), .DATA_WIDTH(DW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bitrev_en(br_a),
    .busy(busy_a), .done(done_a), .axis_tx(tx_a), .axis_mem2m_clken(clken_a),
    .axis_mem2m_raddr(raddr_a), .axis_mem2m_rdata(rdata_a), .m_axis(ax_a)
  );

  axis_mem2s #(.FFT_SIZE(NB), .ADDR_WIDTH(AWB), .DATA_WIDTH(DW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bitrev_en(br_b),
    .busy(busy_b), .done(done_b), .axis_tx(tx_b), .axis_mem2m_clken(clken_b),
    .axis_mem2m_raddr(raddr_b), .axis_mem2m_rdata(rdata_b), .m_axis(ax_b)
  );

  // RAM models: registered read port that holds when disabled.
  logic [DW-1:0] mem_a [NA];
  logic [DW-1:0] mem_b [NB];
  always @(posedge clk) if (clken_a) rdata_a <= mem_a[raddr_a];
  always @(posedge clk) if (clken_b) rdata_b <= mem_b[raddr_b];
  assign ax_b.tready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: reversal by repeated halving, independent of bit slicing.
  function automatic int rev_arith(input int x, input int bits);
    int r = 0;
    int v = x;
    for (int i = 0; i < bits; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  logic [DW-1:0] exp_a [NA];
  task automatic fill_exp(input bit br);
    for (int k = 0; k < int'(NA); k++) exp_a[k] = mem_a[br ? rev_arith(k, AWA) : k];
  endtask

  // Monitor / scoreboard state (owned by the monitor process).
  int   beat_a = 0;
  int   done_cnt = 0;
  int   rd_tb = 0;
  int   gap = 0;
  bit   gap_arm = 0;
  bit   gap_chk_en = 0;
  bit   prev_stall = 0;
  bit   prev_last_hs = 0;
  logic [DW-1:0] prev_data;
  logic prev_last;

  always @(negedge clk) begin
    if (rst) begin
      beat_a = 0; prev_stall = 0; prev_last_hs = 0; gap_arm = 0;
    end else begin
      if (prev_last_hs) chk("done_after_last", 64'(done_a), 64'd1);
      prev_last_hs = 0;
      if (done_a) done_cnt++;
      if (clken_a) rd_tb++;
      if (ax_a.tvalid) begin
        if (gap_arm) begin
          if (gap_chk_en) chk("idle_gap", 64'(gap), 64'd3);
          gap_arm = 0;
        end
        if (prev_stall) begin
          chk("stall_tdata", ax_a.tdata, prev_data);
          chk("stall_tlast", 64'(ax_a.tlast), 64'(prev_last));
        end
        if (!ax_a.tready) begin
          chk("stall_clken", 64'(clken_a), 64'd0);
        end else begin
          chk("tdata", ax_a.tdata, exp_a[beat_a]);
          chk("tlast", 64'(ax_a.tlast), 64'(beat_a == int'(NA) - 1));
          if (ax_a.tlast) begin
            prev_last_hs = 1; gap = 0; gap_arm = 1;
          end
          beat_a = (ax_a.tlast || beat_a == int'(NA) - 1) ? 0 : beat_a + 1;
        end
        prev_stall = !ax_a.tready;
        prev_data  = ax_a.tdata;
        prev_last  = ax_a.tlast;
      end else begin
        prev_stall = 0;
        if (gap_arm) gap++;
      end
    end
  end

  // Ready generator: always-ready, or 50% random with 20-cycle stalls on beat 0 and the last beat.
  int rdy_mode = 0;
  int stall_cnt = 0;
  bit f0 = 0, fl = 0;
  always @(posedge clk) begin
    #1;
    if (!ax_a.tvalid) begin f0 = 0; fl = 0; end
    if (rdy_mode == 0) begin
      ax_a.tready = 1'b1;
    end else if (stall_cnt > 0) begin
      ax_a.tready = 1'b0; stall_cnt--;
    end else if (ax_a.tvalid && beat_a == 0 && !f0) begin
      f0 = 1; stall_cnt = 19; ax_a.tready = 1'b0;
    end else if (ax_a.tvalid && ax_a.tlast && !fl) begin
      fl = 1; stall_cnt = 19; ax_a.tready = 1'b0;
    end else begin
      ax_a.tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  // Pulse start for one cycle, then check the PRIME cycle and first-valid latency.
  task automatic start_frame_a(input bit br);
    @(posedge clk); #1; start_a = 1'b1; br_a = br;
    @(posedge clk); #1; start_a = 1'b0; br_a = 1'b0;
    tick();
    chk("prime_busy", 64'(busy_a), 64'd1);
    chk("prime_tvalid", 64'(ax_a.tvalid), 64'd0);
    chk("prime_clken", 64'(clken_a), 64'd1);
    chk("prime_tx", 64'(tx_a), 64'd1);
    chk("prime_raddr", 64'(raddr_a), 64'd0);
    tick();
    chk("first_tvalid", 64'(ax_a.tvalid), 64'd1);
  endtask

  task automatic wait_done_a(input int limit);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < limit) begin tick(); n++; end
    chk("done_seen", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic wait_beat_a(input int target, input int limit);
    int n = 0;
    while (beat_a != target && n < limit) begin tick(); n++; end
    chk("reach_beat", 64'(beat_a), 64'(target));
  endtask

  int order16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  initial begin
    int r0, d0;
    rst = 1'b1; start_a = 0; br_a = 0; start_b = 0; br_b = 0;
    ax_a.tready = 1'b1;
    for (int i = 0; i < int'(NA); i++) mem_a[i] = {32'($urandom), 32'(i)};
    for (int i = 0; i < int'(NB); i++) mem_b[i] = {32'($urandom), 32'(i)};
    repeat (2) @(posedge clk);
    tick();
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_tx", 64'(tx_a), 64'd0);
    chk("rst_clken", 64'(clken_a), 64'd0);
    chk("rst_tvalid", 64'(ax_a.tvalid), 64'd0);
    chk("rst_tlast", 64'(ax_a.tlast), 64'd0);
    chk("rst_raddr", 64'(raddr_a), 64'd0);
    chk("rst_b_tvalid", 64'(ax_b.tvalid), 64'd0);
    rst = 1'b0;
    tick();

    // Linear frame, always ready.
    fill_exp(1'b0); rdy_mode = 0; r0 = rd_tb; d0 = done_cnt;
    start_frame_a(1'b0);
    wait_done_a(6000);
    repeat (3) tick();
    chk("t1_reads", 64'(rd_tb - r0), 64'(NA));
    chk("t1_dones", 64'(done_cnt - d0), 64'd1);

    // Linear frame, random backpressure.
    rdy_mode = 1; r0 = rd_tb;
    start_frame_a(1'b0);
    wait_done_a(20000);
    chk("t3_reads", 64'(rd_tb - r0), 64'(NA));
    rdy_mode = 0;
    repeat (3) tick();

    // Restart attempt mid-frame is ignored; start held over DONE into IDLE launches the next frame.
    d0 = done_cnt;
    start_frame_a(1'b0);
    wait_beat_a(100, 500);
    start_a = 1'b1; br_a = 1'b1;
    tick();
    start_a = 1'b0; br_a = 1'b0;
    wait_done_a(6000);
    chk("t4_one_done", 64'(done_cnt - d0), 64'd1);
    fill_exp(1'b1); gap_chk_en = 1; r0 = rd_tb;
    start_a = 1'b1; br_a = 1'b1;
    tick();
    tick();
    start_a = 1'b0; br_a = 1'b0;
    chk("b2b_prime_busy", 64'(busy_a), 64'd1);
    chk("b2b_prime_tvalid", 64'(ax_a.tvalid), 64'd0);
    wait_done_a(6000);
    gap_chk_en = 0;
    chk("t2_reads", 64'(rd_tb - r0), 64'(NA));
    repeat (3) tick();

    // Asynchronous reset mid-frame.
    fill_exp(1'b0);
    start_frame_a(1'b0);
    wait_beat_a(1000, 2000);
    d0 = done_cnt;
    #1 rst = 1'b1;
    #1;
    chk("arst_tvalid", 64'(ax_a.tvalid), 64'd0);
    chk("arst_tx", 64'(tx_a), 64'd0);
    chk("arst_clken", 64'(clken_a), 64'd0);
    chk("arst_busy", 64'(busy_a), 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
    r0 = rd_tb;
    start_frame_a(1'b0);
    wait_done_a(6000);
    chk("t5_reads", 64'(rd_tb - r0), 64'(NA));

    // 16-point bit-reversed instance.
    @(posedge clk); #1; start_b = 1'b1; br_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0; br_b = 1'b0;
    tick();
    chk("b_prime_tx", 64'(tx_b), 64'd1);
    chk("b_prime_tvalid", 64'(ax_b.tvalid), 64'd0);
    for (int k = 0; k < int'(NB); k++) begin
      tick();
      chk("b_tvalid", 64'(ax_b.tvalid), 64'd1);
      chk("b_tdata", ax_b.tdata, mem_b[order16[k]]);
      chk("b_tlast", 64'(ax_b.tlast), 64'(k == int'(NB) - 1));
      chk("b_tx", 64'(tx_b), 64'd1);
    end
    tick();
    chk("b_done", 64'(done_b), 64'd1);
    chk("b_tx_off", 64'(tx_b), 64'd0);
    chk("b_tvalid_off", 64'(ax_b.tvalid), 64'd0);
    chk("b_busy_off", 64'(busy_b), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
